// File: rtl/weight_loader_pkg.sv
// Shared definitions for the weight loader: default sizing and FSM state encoding.
// The optional checksum trailer is enabled by defining WL_CHECKSUM_EN (off by default).
package weight_loader_pkg;

  localparam int WL_NUM_NEURONS = 30;
  localparam int WL_MEM_DEPTH   = 784;
  localparam int WL_ADDR_WIDTH  = 10;
  localparam int WL_DATA_WIDTH  = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } wl_state_e;

endpackage

// File: rtl/wl_header_decode.sv
// Combinational frame-header decode: splits the word into neuron id / payload
// count (count in the low ADDR_WIDTH bits) and flags whether the header is legal.
module wl_header_decode
  import weight_loader_pkg::*;
#(
  parameter int NUM_NEURONS = WL_NUM_NEURONS,
  parameter int MEM_DEPTH   = WL_MEM_DEPTH,
  parameter int ADDR_WIDTH  = WL_ADDR_WIDTH,
  parameter int DATA_WIDTH  = WL_DATA_WIDTH,
  parameter int ID_WIDTH    = DATA_WIDTH - ADDR_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] hdr_i,
  output logic [ID_WIDTH-1:0]   id_o,
  output logic [ADDR_WIDTH-1:0] count_o,
  output logic                  legal_o
);

  assign id_o    = hdr_i[DATA_WIDTH-1:ADDR_WIDTH];
  assign count_o = hdr_i[ADDR_WIDTH-1:0];

  // Compare at 32 bits so the limits may exceed the field widths.
  assign legal_o = (32'(id_o) < NUM_NEURONS) &&
                   (count_o != '0) &&
                   (32'(count_o) <= MEM_DEPTH);

endmodule

// File: rtl/weight_loader.sv
// Framed-stream writer for the per-neuron weight memories: header selects the
// neuron and word count, each payload word becomes one registered write. Optional
// trailing checksum word when WL_CHECKSUM_EN is defined.
module weight_loader
  import weight_loader_pkg::*;
#(
  parameter int NUM_NEURONS = WL_NUM_NEURONS,
  parameter int MEM_DEPTH   = WL_MEM_DEPTH,
  parameter int ADDR_WIDTH  = WL_ADDR_WIDTH,
  parameter int DATA_WIDTH  = WL_DATA_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DATA_WIDTH-1:0]  i_data,
  input  logic                   i_valid,
  input  logic                   i_last,
  output logic                   o_ready,
  output logic [NUM_NEURONS-1:0] o_w_en,
  output logic [ADDR_WIDTH-1:0]  o_w_addr,
  output logic [DATA_WIDTH-1:0]  o_w_data,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_err
);

  localparam int ID_WIDTH = DATA_WIDTH - ADDR_WIDTH;

  wl_state_e              state_q, state_d;
  logic [ID_WIDTH-1:0]    id_q, id_d;
  logic [ADDR_WIDTH-1:0]  cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic                   err_q, err_d;
  logic [NUM_NEURONS-1:0] w_en_q, w_en_d;
  logic [ADDR_WIDTH-1:0]  w_addr_q, w_addr_d;
  logic [DATA_WIDTH-1:0]  w_data_q, w_data_d;
`ifdef WL_CHECKSUM_EN
  logic [DATA_WIDTH-1:0]  sum_q, sum_d;
`endif

  logic [ID_WIDTH-1:0]   hdr_id;
  logic [ADDR_WIDTH-1:0] hdr_count;
  logic                  hdr_legal;
  logic                  beat;
  logic                  nth_beat;

  wl_header_decode #(
    .NUM_NEURONS (NUM_NEURONS),
    .MEM_DEPTH   (MEM_DEPTH),
    .ADDR_WIDTH  (ADDR_WIDTH),
    .DATA_WIDTH  (DATA_WIDTH),
    .ID_WIDTH    (ID_WIDTH)
  ) u_hdr (
    .hdr_i   (i_data),
    .id_o    (hdr_id),
    .count_o (hdr_count),
    .legal_o (hdr_legal)
  );

  assign o_ready  = (state_q != ST_DONE);
  assign o_busy   = (state_q != ST_IDLE);
  assign o_done   = (state_q == ST_DONE);
  assign o_err    = err_q;
  assign o_w_en   = w_en_q;
  assign o_w_addr = w_addr_q;
  assign o_w_data = w_data_q;

  assign beat     = i_valid && o_ready;
  assign nth_beat = (addr_q == cnt_q - 1'b1);

  always_comb begin
    // NOTE: every variable gets a default before the case so no path infers a latch.
    state_d  = state_q;
    id_d     = id_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    err_d    = err_q;
    w_en_d   = '0;
    w_addr_d = w_addr_q;
    w_data_d = w_data_q;
`ifdef WL_CHECKSUM_EN
    sum_d    = sum_q;
`endif

    case (state_q)
      ST_IDLE: if (beat) begin
        if (hdr_legal && !i_last) begin
          id_d    = hdr_id;
          cnt_d   = hdr_count;
          addr_d  = '0;
`ifdef WL_CHECKSUM_EN
          sum_d   = '0;
`endif
          state_d = ST_LOAD;
        end else begin
          err_d   = 1'b1;
          state_d = i_last ? ST_IDLE : ST_DRAIN;
        end
      end

      ST_LOAD: if (beat) begin
`ifdef WL_CHECKSUM_EN
        // Counter equal to the count means all payload is in: this beat is the checksum.
        if (addr_q == cnt_q) begin
          if (!i_last) begin
            err_d   = 1'b1;
            state_d = ST_DRAIN;
          end else if (sum_q != i_data) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          w_en_d   = NUM_NEURONS'(1) << id_q;
          w_addr_d = addr_q;
          w_data_d = i_data;
          addr_d   = addr_q + 1'b1;
          sum_d    = sum_q + i_data;
          if (i_last) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end
`else
        w_en_d   = NUM_NEURONS'(1) << id_q;
        w_addr_d = addr_q;
        w_data_d = i_data;
        addr_d   = addr_q + 1'b1;
        if (nth_beat) begin
          err_d   = err_q | !i_last;
          state_d = i_last ? ST_DONE : ST_DRAIN;
        end else if (i_last) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
`endif
      end

      ST_DRAIN: if (beat && i_last) state_d = ST_IDLE;

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

`ifdef WL_CHECKSUM_EN
  // The Nth-beat decode is only needed without the checksum trailer.
  logic unused_nth;
  assign unused_nth = nth_beat;
`endif

  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state_q  <= ST_IDLE;
      id_q     <= '0;
      cnt_q    <= '0;
      addr_q   <= '0;
      err_q    <= 1'b0;
      w_en_q   <= '0;
      w_addr_q <= '0;
      w_data_q <= '0;
`ifdef WL_CHECKSUM_EN
      sum_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      id_q     <= id_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      err_q    <= err_d;
      w_en_q   <= w_en_d;
      w_addr_q <= w_addr_d;
      w_data_q <= w_data_d;
`ifdef WL_CHECKSUM_EN
      sum_q    <= sum_d;
`endif
    end
  end

endmodule

// File: tb/tb_weight_loader.sv
// Self-checking bench for weight_loader: directed and random frames compared
// against a frame-level reference model of the expected writes, done and error.
module tb_weight_loader;

  localparam int NN = 30;
  localparam int MD = 784;
  localparam int AW = 10;
  localparam int DW = 16;
`ifdef WL_CHECKSUM_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic          clk;
  logic          reset;
  logic [DW-1:0] i_data;
  logic          i_valid;
  logic          i_last;
  logic          o_ready;
  logic [NN-1:0] o_w_en;
  logic [AW-1:0] o_w_addr;
  logic [DW-1:0] o_w_data;
  logic          o_busy;
  logic          o_done;
  logic          o_err;

  weight_loader dut (
    .clk      (clk),
    .reset    (reset),
    .i_data   (i_data),
    .i_valid  (i_valid),
    .i_last   (i_last),
    .o_ready  (o_ready),
    .o_w_en   (o_w_en),
    .o_w_addr (o_w_addr),
    .o_w_data (o_w_data),
    .o_busy   (o_busy),
    .o_done   (o_done),
    .o_err    (o_err)
  );

  typedef struct packed {
    logic [NN-1:0] en;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t           obs_q[$];
  wr_t           exp_q[$];
  logic [DW-1:0] frm[$];
  int            n_done;
  int            exp_done;
  bit            exp_err;
  int            errors = 0;
  int            checks = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (o_w_en != '0) obs_q.push_back(wr_t'{o_w_en, o_w_addr, o_w_data});
    if (o_done) n_done++;
  end

  // Frame-level reference: what a whole frame must write, and whether it completes.
  function automatic void model();
    logic [DW-1:0] h;
    logic [DW-1:0] sum;
    logic [NN-1:0] onehot;
    int id, n, p, nw;
    h  = frm[0];
    id = int'(h[DW-1:AW]);
    n  = int'(h[AW-1:0]);
    p  = frm.size() - 1;
    exp_q.delete();
    exp_done = 0;
    if (!(id < NN && n >= 1 && n <= MD) || p == 0) begin
      exp_err = 1'b1;
      return;
    end
    onehot = '0;
    onehot[id] = 1'b1;
    nw = (p < n) ? p : n;
    for (int i = 0; i < nw; i++)
      exp_q.push_back(wr_t'{onehot, AW'(i), frm[i+1]});
    if (!CHK) begin
      if (p == n) exp_done = 1;
      else        exp_err  = 1'b1;
    end else if (p == n + 1) begin
      sum = '0;
      for (int i = 1; i <= n; i++) sum = sum + frm[i];
      if (sum == frm[n+1]) exp_done = 1;
      else                 exp_err  = 1'b1;
    end else begin
      exp_err = 1'b1;
    end
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset   = 1'b1;
    i_valid = 1'b0;
    i_last  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    exp_err = 1'b0;
    obs_q.delete();
    n_done = 0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      i_valid = 1'b0;
      i_data  = DW'($urandom);
      i_last  = 1'($urandom);
    end
  endtask

  task automatic drive_word(input logic [DW-1:0] w, input bit last, output bit ok);
    int waited;
    @(negedge clk);
    i_valid = 1'b1;
    i_data  = w;
    i_last  = last;
    waited  = 0;
    while (!o_ready && waited < 8) begin
      @(negedge clk);
      waited++;
    end
    ok = o_ready;
    @(posedge clk);
  endtask

  task automatic run_frame(input string name, input int min_gap, input int max_gap);
    bit ok;
    model();
    obs_q.delete();
    n_done = 0;
    for (int i = 0; i < frm.size(); i++) begin
      if (i > 0 && max_gap > 0) idle_cycles($urandom_range(max_gap, min_gap));
      drive_word(frm[i], i == frm.size() - 1, ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL %s: ready timeout on word %0d", name, i);
      end
    end
    @(negedge clk);
    i_valid = 1'b0;
    i_last  = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL %s write count: got %0d expected %0d", name, obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL %s write %0d: got en=%h addr=%0d data=%h expected en=%h addr=%0d data=%h",
                 name, i, obs_q[i].en, obs_q[i].addr, obs_q[i].data,
                 exp_q[i].en, exp_q[i].addr, exp_q[i].data);
      end
    end
    checks++;
    if (n_done !== exp_done) begin
      errors++;
      $display("FAIL %s done pulses: got %0d expected %0d", name, n_done, exp_done);
    end
    checks++;
    if (o_err !== exp_err) begin
      errors++;
      $display("FAIL %s err: got %b expected %b", name, o_err, exp_err);
    end
    checks++;
    if (o_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s busy after frame: got %b expected 0", name, o_busy);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({o_w_en, o_w_addr, o_w_data, o_busy, o_done, o_err} !== '0) begin
      errors++;
      $display("FAIL reset outputs: got en=%h addr=%h data=%h busy=%b done=%b err=%b expected all 0",
               o_w_en, o_w_addr, o_w_data, o_busy, o_done, o_err);
    end
    checks++;
    if (o_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset ready: got %b expected 1", o_ready);
    end
  endtask

  task automatic test_legal_frame();
    frm = '{16'h0803, 16'hAAAA, 16'hBBBB, 16'hCCCC};
    run_frame("legal", 0, 0);
  endtask

  task automatic test_backpressure();
    do_reset();
    frm = '{16'h0803, 16'hAAAA, 16'hBBBB, 16'hCCCC};
    run_frame("backpressure", 2, 2);
  endtask

  task automatic test_illegal_id();
    do_reset();
    frm = '{16'h7C02, 16'h1111, 16'h2222};
    run_frame("illegal_id", 0, 0);
    frm = '{16'h0401, 16'h5555};
    run_frame("after_illegal", 0, 1);
  endtask

  task automatic test_length_mismatch();
    do_reset();
    frm = '{16'h0C04, 16'h0101, 16'h0202};
    run_frame("early_last", 0, 0);
    do_reset();
    frm = '{16'h0C02, 16'h0303, 16'h0404, 16'h0505};
    run_frame("late_last", 0, 0);
  endtask

  task automatic test_boundaries();
    do_reset();
    frm = '{16'h0800, 16'h1234};
    run_frame("count_zero", 0, 0);
    do_reset();
    frm = '{16'h0803};
    run_frame("last_on_header", 0, 0);
    do_reset();
    frm = '{16'h7801, 16'h4321};
    run_frame("id_30", 0, 0);
    do_reset();
    frm = '{16'h0800 | 16'(MD + 1), 16'h0001};
    run_frame("count_785", 0, 0);
    do_reset();
    frm = '{16'h7400 | 16'(MD)};
    for (int i = 0; i < MD; i++) frm.push_back(DW'($urandom));
    if (CHK) frm.push_back(16'h0000);
    run_frame("id29_full_depth", 0, 0);
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    do_reset();
    drive_word(16'h0803, 1'b0, ok);
    drive_word(16'hAAAA, 1'b0, ok);
    @(negedge clk);
    reset   = 1'b1;
    i_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({o_w_en, o_w_addr, o_w_data, o_busy, o_done, o_err} !== '0) begin
      errors++;
      $display("FAIL mid_reset outputs: got en=%h addr=%h data=%h busy=%b done=%b err=%b expected all 0",
               o_w_en, o_w_addr, o_w_data, o_busy, o_done, o_err);
    end
    reset   = 1'b0;
    exp_err = 1'b0;
    frm = '{16'h0402, 16'h1234, 16'h5678};
    if (CHK) frm.push_back(16'h68AC);
    run_frame("after_mid_reset", 0, 0);
  endtask

  task automatic test_checksum();
`ifdef WL_CHECKSUM_EN
    do_reset();
    frm = '{16'h0802, 16'h0001, 16'h0002, 16'h0003};
    run_frame("checksum_ok", 0, 1);
    do_reset();
    frm = '{16'h0802, 16'h0001, 16'h0002, 16'h0004};
    run_frame("checksum_bad", 0, 1);
    do_reset();
    frm = '{16'h0802, 16'h0001, 16'h0002};
    run_frame("checksum_missing", 0, 0);
`endif
  endtask

  task automatic test_random();
    int id, n, p;
    logic [DW-1:0] sum;
    do_reset();
    for (int f = 0; f < 30; f++) begin
      id = ($urandom_range(7, 0) == 0) ? $urandom_range(63, 30) : $urandom_range(29, 0);
      n  = ($urandom_range(15, 0) == 0) ? 0 : $urandom_range(6, 1);
      p  = n + int'(CHK) + (($urandom_range(4, 0) == 0) ? 1 : 0)
             - (($urandom_range(4, 0) == 1) ? 1 : 0);
      if (p < 1) p = 1;
      frm.delete();
      frm.push_back({6'(id), 10'(n)});
      sum = '0;
      for (int i = 0; i < p; i++) begin
        frm.push_back(DW'($urandom));
        if (i < n) sum = sum + frm[i+1];
      end
      if (CHK && p == n + 1 && $urandom_range(3, 0) != 0) frm[p] = sum;
      run_frame("random", 0, 2);
      if ($urandom_range(5, 0) == 0) do_reset();
    end
  endtask

  initial begin
    reset   = 1'b1;
    i_valid = 1'b0;
    i_last  = 1'b0;
    i_data  = '0;
    n_done  = 0;
    exp_err = 1'b0;
    test_reset();
    test_legal_frame();
    test_backpressure();
    test_illegal_id();
    test_length_mismatch();
    test_boundaries();
    test_reset_mid_frame();
    test_checksum();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
